// File: rtl/wavegen_pkg.sv
// Shared definitions for the waveform-generator datapath: accumulator FSM
// states and the default accumulator / phase widths.
package wavegen_pkg;

  localparam int unsigned DEFAULT_ACC_W   = 32;
  localparam int unsigned DEFAULT_PHASE_W = 12;

  // IDLE: no frequency running yet, RUN: free-running, PENDING: retune waits for wrap
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } acc_state_e;

endpackage

// File: rtl/phase_sweep_ctrl.sv
// Linear frequency sweep helper for phase_accumulator (built only under
// PHASE_ACC_SWEEP_EN). Each accumulator wrap steps the frequency word up by
// sweep_step until it reaches sweep_stop_fcw, where it clamps and stops.
module phase_sweep_ctrl
  import wavegen_pkg::*;
#(
  parameter int unsigned ACC_W = DEFAULT_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             wrap,
  input  logic [ACC_W-1:0] active_fcw,
  input  logic [ACC_W-1:0] sweep_step,
  input  logic [ACC_W-1:0] sweep_stop_fcw,
  output logic             sweep_active,
  output logic             fcw_load,
  output logic [ACC_W-1:0] fcw_next
);

  logic             sweep_active_q;
  logic [ACC_W:0]   step_sum;
  logic             reached;

  // One extra bit so a step past 2^ACC_W still compares correctly against the stop word
  assign step_sum     = {1'b0, active_fcw} + {1'b0, sweep_step};
  assign reached      = step_sum >= {1'b0, sweep_stop_fcw};
  assign fcw_load     = sweep_active_q & wrap;
  assign fcw_next     = reached ? sweep_stop_fcw : step_sum[ACC_W-1:0];
  assign sweep_active = sweep_active_q;

  // Sweep runs from start until the clamped step is applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_active_q <= 1'b0;
    end else if (start) begin
      sweep_active_q <= 1'b1;
    end else if (fcw_load && reached) begin
      sweep_active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/phase_accumulator.sv
// phase_accumulator: NCO phase accumulator feeding the waveform generators.
// A new frequency word is taken immediately while idle; once running it is
// parked and only applied on the accumulator wrap (or a phase sync) so each
// output period completes at the old frequency.
// Optional linear sweep is built only when PHASE_ACC_SWEEP_EN is defined.
module phase_accumulator
  import wavegen_pkg::*;
#(
  parameter int unsigned ACC_W   = DEFAULT_ACC_W,
  parameter int unsigned PHASE_W = DEFAULT_PHASE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [ACC_W-1:0]   fcw,
  input  logic               fcw_valid,
  output logic               fcw_ready,
  input  logic [PHASE_W-1:0] phase_offset,
  input  logic               phase_sync,
  output logic [PHASE_W-1:0] phase_out,
  output logic               wrap_pulse,
  input  logic               sweep_start,
  input  logic [ACC_W-1:0]   sweep_step,
  input  logic [ACC_W-1:0]   sweep_stop_fcw,
  output logic               sweep_active
);

  acc_state_e         state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   active_fcw_q;
  logic [ACC_W-1:0]   pending_fcw_q;
  logic [PHASE_W-1:0] phase_out_q;
  logic               wrap_pulse_q;

  logic [ACC_W:0]     acc_sum;
  logic               wrap_evt;
  logic               fcw_fire;
  logic               pend_apply;
  logic               sweep_act;
  logic               sweep_load;
  logic [ACC_W-1:0]   sweep_fcw;

  assign acc_sum    = {1'b0, acc_q} + {1'b0, active_fcw_q};
  // A sync in the same cycle as a carry suppresses the wrap
  assign wrap_evt   = enable & ~phase_sync & acc_sum[ACC_W];
  assign fcw_ready  = (state_q != PENDING) & ~sweep_act;
  assign fcw_fire   = fcw_valid & fcw_ready;
  // A zero step would never wrap, so apply at once to avoid deadlock
  assign pend_apply = (state_q == PENDING) &
                      (wrap_evt | phase_sync | (active_fcw_q == '0));

`ifdef PHASE_ACC_SWEEP_EN
  logic sweep_go;

  assign sweep_go = (state_q == RUN) & sweep_start & ~fcw_fire & ~sweep_act;

  phase_sweep_ctrl #(
    .ACC_W (ACC_W)
  ) u_sweep (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (sweep_go),
    .wrap           (wrap_evt),
    .active_fcw     (active_fcw_q),
    .sweep_step     (sweep_step),
    .sweep_stop_fcw (sweep_stop_fcw),
    .sweep_active   (sweep_act),
    .fcw_load       (sweep_load),
    .fcw_next       (sweep_fcw)
  );
`else
  logic unused_sweep;

  assign unused_sweep = ^{sweep_start, sweep_step, sweep_stop_fcw};
  assign sweep_act    = 1'b0;
  assign sweep_load   = 1'b0;
  assign sweep_fcw    = '0;
`endif

  assign sweep_active = sweep_act;
  assign phase_out    = phase_out_q;
  assign wrap_pulse   = wrap_pulse_q;

  // Retune FSM: owns the active and parked frequency words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      active_fcw_q  <= '0;
      pending_fcw_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fcw_fire) begin
            active_fcw_q <= fcw;
          end
          if (enable) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (fcw_fire) begin
            pending_fcw_q <= fcw;
            state_q       <= PENDING;
          end else if (sweep_load) begin
            active_fcw_q <= sweep_fcw;
          end
        end
        PENDING: begin
          if (pend_apply) begin
            active_fcw_q <= pending_fcw_q;
            state_q      <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accumulator, wrap flag and registered output phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      wrap_pulse_q <= 1'b0;
      phase_out_q  <= '0;
    end else begin
      if (phase_sync) begin
        acc_q <= '0;
      end else if (enable) begin
        acc_q <= acc_sum[ACC_W-1:0];
      end
      wrap_pulse_q <= wrap_evt;
      if (enable) begin
        phase_out_q <= acc_q[ACC_W-1 -: PHASE_W] + phase_offset;
      end
    end
  end

endmodule
